// File: rtl/alu_pkg.sv
// Shared opcode constants, ALU control codes and decode result type.
package alu_pkg;

  localparam int CTRL_W = 4;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd15
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_R    = 2'd1,
    CLS_I    = 2'd2,
    CLS_B    = 2'd3
  } instr_cls_e;

  // imm_i is already the final data2 value for I-type (shamt zero-extended
  // for shifts); both immediates are 32-bit and sign-extended by the stage.
  typedef struct packed {
    alu_ctrl_e   ctrl;
    instr_cls_e  cls;
    logic        illegal;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
  } dec_t;

  // funct3 to ALU op; alt selects SUB/SRA (instr bit 30 / funct7 alt).
  function automatic alu_ctrl_e alu_op_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-to-ALU control/operand interface; the issue stage is the master.
interface alu_issue_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
);
  logic              valid_o;
  logic              ready_i;
  logic [XLEN-1:0]   data1_o;
  logic [XLEN-1:0]   data2_o;
  logic [CTRL_W-1:0] ALUCtrl_o;
  logic [4:0]        rd_o;
  logic              regWrite_o;
  logic              branch_o;
  logic [2:0]        brFunct3_o;
  logic [XLEN-1:0]   imm_o;
  logic [XLEN-1:0]   pc_o;
  logic              illegal_o;

  modport master (
    output valid_o, data1_o, data2_o, ALUCtrl_o, rd_o, regWrite_o,
           branch_o, brFunct3_o, imm_o, pc_o, illegal_o,
    input  ready_i
  );

  modport slave (
    input  valid_o, data1_o, data2_o, ALUCtrl_o, rd_o, regWrite_o,
           branch_o, brFunct3_o, imm_o, pc_o, illegal_o,
    output ready_i
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I R/I-ALU/branch decode into ALU op, immediates, class.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  assign w_op = i_instr[6:0];
  assign w_f3 = i_instr[14:12];
  assign w_f7 = i_instr[31:25];

  // Classify the instruction and flag encodings the ALU path does not support.
  always_comb begin
    o_dec.ctrl    = ALU_ADD;
    o_dec.cls     = CLS_NONE;
    o_dec.illegal = 1'b0;
    o_dec.imm_i   = {{20{i_instr[31]}}, i_instr[31:20]};
    o_dec.imm_b   = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                     i_instr[30:25], i_instr[11:8], 1'b0};
    case (w_op)
      OP_R: begin
        o_dec.cls = CLS_R;
        if (w_f7 == F7_BASE)
          o_dec.ctrl = alu_op_f3(w_f3, 1'b0);
        else if (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))
          o_dec.ctrl = alu_op_f3(w_f3, 1'b1);
        else
          o_dec.illegal = 1'b1;
      end
      OP_I: begin
        o_dec.cls = CLS_I;
        case (w_f3)
          3'b001: begin
            o_dec.ctrl    = ALU_SLL;
            o_dec.imm_i   = {27'd0, i_instr[24:20]};
            o_dec.illegal = (w_f7 != F7_BASE);
          end
          3'b101: begin
            o_dec.ctrl    = alu_op_f3(w_f3, i_instr[30]);
            o_dec.imm_i   = {27'd0, i_instr[24:20]};
            o_dec.illegal = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
          end
          // ADDI never becomes SUB, whatever bit 30 holds.
          default: o_dec.ctrl = alu_op_f3(w_f3, 1'b0);
        endcase
      end
      OP_B: begin
        o_dec.cls = CLS_B;
        case (w_f3)
          3'b000, 3'b001: o_dec.ctrl = ALU_SUB;
          3'b100, 3'b101: o_dec.ctrl = ALU_SLT;
          3'b110, 3'b111: o_dec.ctrl = ALU_SLTU;
          default:        o_dec.illegal = 1'b1;
        endcase
      end
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decode, operand bypass from EX/WB, valid/ready hold.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            exFwdEn_i,
  input  logic            wbFwdEn_i,
  input  logic [4:0]      exFwdRd_i,
  input  logic [4:0]      wbFwdRd_i,
  input  logic [XLEN-1:0] exFwdData_i,
  input  logic [XLEN-1:0] wbFwdData_i,
  input  logic            flush_i,
  alu_issue_if.master     ex_if
);

  dec_t              w_dec;
  logic              w_xfer;
  logic              w_is_b;
  logic [XLEN-1:0]   w_src1;
  logic [XLEN-1:0]   w_src2;
  logic [XLEN-1:0]   w_imm_i;
  logic [XLEN-1:0]   w_imm_b;

  logic              r_valid;
  logic              r_illegal;
  logic [XLEN-1:0]   r_data1;
  logic [XLEN-1:0]   r_data2;
  logic [CTRL_W-1:0] r_ctrl;
  logic [4:0]        r_rd;
  logic              r_regwrite;
  logic              r_branch;
  logic [2:0]        r_brf3;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_pc;

  alu_decode u_dec (
    .i_instr (instr_i),
    .o_dec   (w_dec)
  );

  // x0 is hardwired; the younger EX result shadows the older WB result.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf,
    input logic            ex_en,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_d,
    input logic            wb_en,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_d
  );
    if (rs == 5'd0)                 return '0;
    else if (ex_en && ex_rd == rs)  return ex_d;
    else if (wb_en && wb_rd == rs)  return wb_d;
    else                            return rf;
  endfunction

  assign ready_o = !r_valid || ex_if.ready_i || flush_i;
  assign w_xfer  = valid_i && ready_o;
  assign w_is_b  = (w_dec.cls == CLS_B);
  assign w_imm_i = XLEN'($signed(w_dec.imm_i));
  assign w_imm_b = XLEN'($signed(w_dec.imm_b));
  assign w_src1  = resolve(instr_i[19:15], rs1_data_i, exFwdEn_i, exFwdRd_i,
                           exFwdData_i, wbFwdEn_i, wbFwdRd_i, wbFwdData_i);
  assign w_src2  = (w_dec.cls == CLS_I) ? w_imm_i :
                   resolve(instr_i[24:20], rs2_data_i, exFwdEn_i, exFwdRd_i,
                           exFwdData_i, wbFwdEn_i, wbFwdRd_i, wbFwdData_i);

  // Pipeline register: load on transfer, hold under backpressure, drain on consume.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid    <= 1'b0;
      r_illegal  <= 1'b0;
      r_data1    <= '0;
      r_data2    <= '0;
      r_ctrl     <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_brf3     <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
    end else if (flush_i) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      if (w_xfer) begin
        if (w_dec.illegal) begin
          r_valid   <= 1'b0;
          r_illegal <= 1'b1;
        end else begin
          r_valid    <= 1'b1;
          r_data1    <= w_src1;
          r_data2    <= w_src2;
          r_ctrl     <= CTRL_W'(w_dec.ctrl);
          r_rd       <= w_is_b ? 5'd0 : instr_i[11:7];
          r_regwrite <= !w_is_b;
          r_branch   <= w_is_b;
          r_brf3     <= w_is_b ? instr_i[14:12] : 3'd0;
          r_imm      <= w_is_b ? w_imm_b : '0;
          r_pc       <= pc_i;
        end
      end else if (ex_if.ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ex_if.valid_o    = r_valid;
  assign ex_if.illegal_o  = r_illegal;
  assign ex_if.data1_o    = r_data1;
  assign ex_if.data2_o    = r_data2;
  assign ex_if.ALUCtrl_o  = r_ctrl;
  assign ex_if.rd_o       = r_rd;
  assign ex_if.regWrite_o = r_regwrite;
  assign ex_if.branch_o   = r_branch;
  assign ex_if.brFunct3_o = r_brf3;
  assign ex_if.imm_o      = r_imm;
  assign ex_if.pc_o       = r_pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode/forward vector table plus
// hand-written backpressure, flush and reset sequences.
module tb_alu_issue_stage;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic            ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] rs1_data_i, rs2_data_i;
  logic            exFwdEn_i, wbFwdEn_i;
  logic [4:0]      exFwdRd_i, wbFwdRd_i;
  logic [XLEN-1:0] exFwdData_i, wbFwdData_i;
  logic            flush_i;

  int checks = 0;
  int failures = 0;

  alu_issue_if #(.XLEN(XLEN), .CTRL_W(4)) ex_if ();

  alu_issue_stage #(.XLEN(XLEN), .CTRL_W(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .exFwdEn_i   (exFwdEn_i),
    .wbFwdEn_i   (wbFwdEn_i),
    .exFwdRd_i   (exFwdRd_i),
    .wbFwdRd_i   (wbFwdRd_i),
    .exFwdData_i (exFwdData_i),
    .wbFwdData_i (wbFwdData_i),
    .flush_i     (flush_i),
    .ex_if       (ex_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1d, rs2d;
    logic [31:0] exen, exrd, exd;
    logic [31:0] wben, wbrd, wbd;
    logic [31:0] ev, eill, ectrl, ed1, ed2, erd, erw, ebr, ef3, eimm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] pc);
    valid_i = 1'b1; instr_i = instr; rs1_data_i = r1; rs2_data_i = r2; pc_i = pc;
  endtask

  task automatic no_fwd();
    exFwdEn_i = 1'b0; exFwdRd_i = '0; exFwdData_i = '0;
    wbFwdEn_i = 1'b0; wbFwdRd_i = '0; wbFwdData_i = '0;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  initial begin
    //            instr          rs1d          rs2d   ex: en rd data    wb: en rd data  v ill ctl d1            d2            rd rw br f3 imm
    vecs.push_back('{32'h402081B3, 10,          3,     0,0,0,           0,0,0,          1,0, 1, 10,           3,            3, 1, 0, 0, 0});            // SUB
    vecs.push_back('{32'h40435293, 32'h80000000,0,     0,0,0,           0,0,0,          1,0, 7, 32'h80000000, 4,            5, 1, 0, 0, 0});            // SRAI 4
    vecs.push_back('{32'h02435293, 5,           0,     0,0,0,           0,0,0,          0,1, 0, 0,            0,            0, 0, 0, 0, 0});            // bad SRxI
    vecs.push_back('{32'hFFF08393, 20,          0,     0,0,0,           0,0,0,          1,0, 0, 20,           32'hFFFFFFFF, 7, 1, 0, 0, 0});            // ADDI -1
    vecs.push_back('{32'hFE20ECE3, 1,           2,     0,0,0,           0,0,0,          1,0, 4, 1,            2,            0, 0, 1, 6, 32'hFFFFFFF8}); // BLTU -8
    vecs.push_back('{32'h00628433, 32'h33,      32'h77,1,5,32'hAA,      1,5,32'hBB,     1,0, 0, 32'hAA,       32'h77,       8, 1, 0, 0, 0});            // EX beats WB
    vecs.push_back('{32'h00628433, 32'h33,      32'h77,1,7,32'hEE,      1,6,32'hCC,     1,0, 0, 32'h33,       32'hCC,       8, 1, 0, 0, 0});            // WB on rs2
    vecs.push_back('{32'h006004B3, 32'h55,      32'h11,1,0,32'hDD,      0,6,32'h99,     1,0, 0, 0,            32'h11,       9, 1, 0, 0, 0});            // x0, WB disabled
    vecs.push_back('{32'h000012B7, 0,           0,     0,0,0,           0,0,0,          0,1, 0, 0,            0,            0, 0, 0, 0, 0});            // LUI
    vecs.push_back('{32'h00002063, 0,           0,     0,0,0,           0,0,0,          0,1, 0, 0,            0,            0, 0, 0, 0, 0});            // branch f3=010
    vecs.push_back('{32'h02309113, 0,           0,     0,0,0,           0,0,0,          0,1, 0, 0,            0,            0, 0, 0, 0, 0});            // bad SLLI
    vecs.push_back('{32'h00309113, 7,           0,     0,0,0,           0,0,0,          1,0, 2, 7,            3,            2, 1, 0, 0, 0});            // SLLI 3
    vecs.push_back('{32'h4020C1B3, 0,           0,     0,0,0,           0,0,0,          0,1, 0, 0,            0,            0, 0, 0, 0, 0});            // alt f7 on XOR
    vecs.push_back('{32'h0020A1B3, 5,           6,     0,0,0,           0,0,0,          1,0, 3, 5,            6,            3, 1, 0, 0, 0});            // SLT
    vecs.push_back('{32'h0020B1B3, 5,           6,     0,0,0,           0,0,0,          1,0, 4, 5,            6,            3, 1, 0, 0, 0});            // SLTU
    vecs.push_back('{32'h0020D1B3, 5,           6,     0,0,0,           0,0,0,          1,0, 6, 5,            6,            3, 1, 0, 0, 0});            // SRL
    vecs.push_back('{32'h4020D1B3, 5,           6,     0,0,0,           0,0,0,          1,0, 7, 5,            6,            3, 1, 0, 0, 0});            // SRA
    vecs.push_back('{32'h0020E1B3, 5,           6,     0,0,0,           0,0,0,          1,0, 8, 5,            6,            3, 1, 0, 0, 0});            // OR
    vecs.push_back('{32'h7FF0C193, 1,           0,     0,0,0,           0,0,0,          1,0, 5, 1,            32'h7FF,      3, 1, 0, 0, 0});            // XORI
    vecs.push_back('{32'h0F00F193, 1,           0,     0,0,0,           0,0,0,          1,0, 9, 1,            32'hF0,       3, 1, 0, 0, 0});            // ANDI
    vecs.push_back('{32'h00208463, 4,           4,     0,0,0,           0,0,0,          1,0, 1, 4,            4,            0, 0, 1, 0, 8});            // BEQ +8
    vecs.push_back('{32'h0020D463, 9,           8,     0,0,0,           0,0,0,          1,0, 3, 9,            8,            0, 0, 1, 5, 8});            // BGE +8

    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ex_if.ready_i = 1'b1;
    instr_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    no_fwd();
    tick(); tick();
    chk("rst_valid",   32'(ex_if.valid_o), 0);
    chk("rst_illegal", 32'(ex_if.illegal_o), 0);
    chk("rst_data1",   ex_if.data1_o, 0);
    chk("rst_ctrl",    32'(ex_if.ALUCtrl_o), 0);
    chk("rst_ready",   32'(ready_o), 1);

    @(negedge clk_i); rst_i = 1'b0;

    // Table: one instruction per cycle with EX always ready.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      drive(vecs[i].instr, vecs[i].rs1d, vecs[i].rs2d, 32'h100 + 32'(i) * 4);
      exFwdEn_i = vecs[i].exen[0]; exFwdRd_i = vecs[i].exrd[4:0]; exFwdData_i = vecs[i].exd;
      wbFwdEn_i = vecs[i].wben[0]; wbFwdRd_i = vecs[i].wbrd[4:0]; wbFwdData_i = vecs[i].wbd;
      tick();
      chk($sformatf("v%0d_valid", i),   32'(ex_if.valid_o),   vecs[i].ev);
      chk($sformatf("v%0d_illegal", i), 32'(ex_if.illegal_o), vecs[i].eill);
      if (vecs[i].ev[0]) begin
        chk($sformatf("v%0d_ctrl", i),  32'(ex_if.ALUCtrl_o),  vecs[i].ectrl);
        chk($sformatf("v%0d_data1", i), ex_if.data1_o,         vecs[i].ed1);
        chk($sformatf("v%0d_data2", i), ex_if.data2_o,         vecs[i].ed2);
        chk($sformatf("v%0d_rd", i),    32'(ex_if.rd_o),       vecs[i].erd);
        chk($sformatf("v%0d_rw", i),    32'(ex_if.regWrite_o), vecs[i].erw);
        chk($sformatf("v%0d_br", i),    32'(ex_if.branch_o),   vecs[i].ebr);
        chk($sformatf("v%0d_f3", i),    32'(ex_if.brFunct3_o), vecs[i].ef3);
        chk($sformatf("v%0d_imm", i),   ex_if.imm_o,           vecs[i].eimm);
        chk($sformatf("v%0d_pc", i),    ex_if.pc_o,            32'h100 + 32'(i) * 4);
      end
    end

    // Drain: no new input, EX consumes.
    @(negedge clk_i); valid_i = 1'b0; no_fwd();
    tick();
    chk("drain_valid", 32'(ex_if.valid_o), 0);

    // Illegal pulse lasts exactly one cycle.
    @(negedge clk_i); drive(32'h000012B7, 0, 0, 32'h200);
    tick();
    chk("ill_pulse", 32'(ex_if.illegal_o), 1);
    @(negedge clk_i); valid_i = 1'b0;
    tick();
    chk("ill_clear", 32'(ex_if.illegal_o), 0);
    chk("ill_novalid", 32'(ex_if.valid_o), 0);

    // Backpressure: A issued, B offered while EX stalls for three cycles.
    @(negedge clk_i); drive(32'hFFF08393, 32'h1234, 0, 32'h300);  // A: ADDI x7,x1,-1
    tick();
    chk("bp_a_valid", 32'(ex_if.valid_o), 1);
    @(negedge clk_i);
    ex_if.ready_i = 1'b0;
    drive(32'h0020A1B3, 32'h21, 32'h22, 32'h304);                  // B: SLT x3,x1,x2
    exFwdEn_i = 1'b1; exFwdRd_i = 5'd1; exFwdData_i = 32'h5A5A;
    #1 chk("bp_ready_low", 32'(ready_o), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp_hold%0d_valid", c), 32'(ex_if.valid_o), 1);
      chk($sformatf("bp_hold%0d_data1", c), ex_if.data1_o, 32'h1234);
      chk($sformatf("bp_hold%0d_data2", c), ex_if.data2_o, 32'hFFFFFFFF);
      chk($sformatf("bp_hold%0d_rd", c),    32'(ex_if.rd_o), 7);
      chk($sformatf("bp_hold%0d_pc", c),    ex_if.pc_o, 32'h300);
    end
    @(negedge clk_i); ex_if.ready_i = 1'b1;
    #1 chk("bp_ready_high", 32'(ready_o), 1);
    tick();
    chk("bp_b_valid", 32'(ex_if.valid_o), 1);
    chk("bp_b_ctrl",  32'(ex_if.ALUCtrl_o), 3);
    chk("bp_b_data1", ex_if.data1_o, 32'h5A5A);
    chk("bp_b_data2", ex_if.data2_o, 32'h22);
    chk("bp_b_pc",    ex_if.pc_o, 32'h304);

    // Flush during hold with a new instruction offered.
    @(negedge clk_i); ex_if.ready_i = 1'b0; no_fwd();
    drive(32'h00309113, 7, 0, 32'h308);
    flush_i = 1'b1;
    #1 chk("fl_ready", 32'(ready_o), 1);
    tick();
    chk("fl_valid",   32'(ex_if.valid_o), 0);
    chk("fl_illegal", 32'(ex_if.illegal_o), 0);
    @(negedge clk_i); flush_i = 1'b0; valid_i = 1'b0;
    tick();
    chk("fl_dropped", 32'(ex_if.valid_o), 0);

    // Flush alongside an illegal instruction suppresses the pulse.
    @(negedge clk_i); ex_if.ready_i = 1'b1; drive(32'h000012B7, 0, 0, 32'h30C); flush_i = 1'b1;
    tick();
    chk("fl_ill_pulse", 32'(ex_if.illegal_o), 0);
    @(negedge clk_i); flush_i = 1'b0; valid_i = 1'b0;

    // Reset while an instruction is held.
    @(negedge clk_i); ex_if.ready_i = 1'b0; drive(32'hFE20ECE3, 1, 2, 32'h400);
    tick();
    chk("rs_pre_valid", 32'(ex_if.valid_o), 1);
    @(negedge clk_i); rst_i = 1'b1; drive(32'h402081B3, 10, 3, 32'h404);
    tick();
    chk("rs_valid",  32'(ex_if.valid_o), 0);
    chk("rs_data1",  ex_if.data1_o, 0);
    chk("rs_data2",  ex_if.data2_o, 0);
    chk("rs_ctrl",   32'(ex_if.ALUCtrl_o), 0);
    chk("rs_branch", 32'(ex_if.branch_o), 0);
    chk("rs_imm",    ex_if.imm_o, 0);
    chk("rs_pc",     ex_if.pc_o, 0);
    chk("rs_f3",     32'(ex_if.brFunct3_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
